// File: rtl/sphere_pair_scheduler.sv
// sphere_pair_scheduler: packs host load words into the sphere-pair RAM,
// then streams complete 8-word pair records into the dCollideSpheres
// pipeline one pair per cycle, tracks in-flight pairs, counts contacts
// and pulses done when every issued pair has returned a result.
module sphere_pair_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_DEPTH      = 32,
    parameter int WORDS_PER_PAIR = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    input  logic                  flush,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            pair_count,
    output logic [7:0]            hit_count,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  pipe_valid,
    input  logic                  res_valid,
    input  logic                  res_hit
);

    localparam int PTR_W  = $clog2(RAM_DEPTH) + 1;
    localparam int NPAIRS = RAM_DEPTH / WORDS_PER_PAIR;
    localparam int CNT_W  = $clog2(NPAIRS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_inflight;
    logic             r_pipe_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_hit_count;

    logic             w_idle;
    logic             w_ld_ready;
    logic             w_load;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_pairs;
    logic [CNT_W-1:0] w_pairs_nxt;
    logic             w_res_ok;
    logic             w_res_err;
    logic [CNT_W-1:0] w_inflight_nxt;

    assign w_idle = (r_state == S_IDLE);

    // The store accepts words only in IDLE while it has room; a flush in the
    // same cycle wins, so the offered word is dropped rather than written.
    assign w_ld_ready = rst_n & w_idle & (r_wr_ptr < PTR_W'(RAM_DEPTH));
    assign w_load     = w_ld_ready & ld_valid & ~flush;

    assign w_wr_ptr_nxt = (w_idle & flush) ? '0 :
                          w_load           ? r_wr_ptr + 1'b1 :
                                             r_wr_ptr;

    // Only whole records count; a trailing partial record is never issued.
    assign w_pairs     = CNT_W'(r_wr_ptr / PTR_W'(WORDS_PER_PAIR));
    assign w_pairs_nxt = CNT_W'(w_wr_ptr_nxt / PTR_W'(WORDS_PER_PAIR));

    // A result is legitimate only if something is in flight, counting a pair
    // entering the pipeline in this very cycle.
    assign w_res_ok  = res_valid & ((r_inflight != '0) | r_pipe_valid);
    assign w_res_err = res_valid & ~w_res_ok;

    // In-flight bookkeeping: issue adds one, an accepted result removes one.
    always_comb begin
        // NOTE: give every always_comb target a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        w_inflight_nxt = r_inflight;
        if (r_pipe_valid & ~w_res_ok) begin
            w_inflight_nxt = r_inflight + 1'b1;
        end else if (~r_pipe_valid & w_res_ok) begin
            w_inflight_nxt = r_inflight - 1'b1;
        end
    end

    // RAM control: write port during IDLE loads, read port during RUN/LAST.
    always_comb begin
        ram_cs       = 1'b0;
        ram_we       = 1'b0;
        ram_oe       = 1'b0;
        ram_addr_in  = '0;
        ram_addr_out = '0;
        ram_din      = '0;
        if (w_load) begin
            ram_cs      = 1'b1;
            ram_we      = 1'b1;
            ram_addr_in = ADDR_WIDTH'(r_wr_ptr);
            ram_din     = ld_data;
        end
        if (r_state == S_RUN || r_state == S_LAST) begin
            ram_cs       = 1'b1;
            ram_oe       = 1'b1;
            ram_addr_out = ADDR_WIDTH'(r_rd_idx) * ADDR_WIDTH'(WORDS_PER_PAIR);
        end
    end

    // Main controller: state, pointers, counters and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_idx     <= '0;
            r_inflight   <= '0;
            r_pipe_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_hit_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; later assignments in this
            // block deliberately override earlier ones (e.g. clears on start).
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_inflight   <= w_inflight_nxt;
            r_pipe_valid <= (r_state == S_RUN);
            r_done       <= 1'b0;

            if (w_res_err) begin
                r_err <= 1'b1;
            end
            if (w_res_ok && res_hit && r_hit_count != 8'hFF) begin
                r_hit_count <= r_hit_count + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_pairs_nxt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_rd_idx    <= '0;
                            r_hit_count <= '0;
                            r_err       <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Hold the index on the final issue so LAST keeps the
                    // last pair address on the RAM read port.
                    if (r_rd_idx == w_pairs - 1'b1) begin
                        r_state <= S_LAST;
                    end else begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
                S_LAST: begin
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_inflight_nxt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready   = w_ld_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign pipe_valid = r_pipe_valid;
    assign hit_count  = r_hit_count;
    assign pair_count = 8'(w_pairs);

endmodule

// File: tb/tb_sphere_pair_scheduler.sv
// Directed bench for sphere_pair_scheduler: a cycle-by-cycle vector table
// for loads, flush, empty run, error and a two-pair run, plus hand-written
// sequences for partial records, the full store and reset during DRAIN.
module tb_sphere_pair_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [7:0]  pair_count, hit_count;
    logic        ram_cs, ram_we, ram_oe;
    logic [31:0] ram_addr_in, ram_addr_out, ram_din;
    logic        pipe_valid;
    logic        res_valid = 1'b0;
    logic        res_hit = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sphere_pair_scheduler #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(32), .WORDS_PER_PAIR(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .flush(flush), .start(start),
        .busy(busy), .done(done), .err(err),
        .pair_count(pair_count), .hit_count(hit_count),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr_in(ram_addr_in), .ram_addr_out(ram_addr_out), .ram_din(ram_din),
        .pipe_valid(pipe_valid), .res_valid(res_valid), .res_hit(res_hit)
    );

    typedef struct {
        string       name;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        flush;
        logic        start;
        logic        res_valid;
        logic        res_hit;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected/actual output image:
    // {ld_ready, cs, we, oe, addr_in, addr_out, din, pipe_valid, busy, done, err, pair_count, hit_count}
    function automatic logic [127:0] pk(logic rdy, logic cs, logic we, logic oe,
                                        logic [31:0] ain, logic [31:0] aout, logic [31:0] din,
                                        logic pv, logic bz, logic dn, logic er,
                                        logic [7:0] pc, logic [7:0] hc);
        return {8'h00, rdy, cs, we, oe, ain, aout, din, pv, bz, dn, er, pc, hc};
    endfunction

    function automatic logic [127:0] act();
        return pk(ld_ready, ram_cs, ram_we, ram_oe, ram_addr_in, ram_addr_out, ram_din,
                  pipe_valid, busy, done, err, pair_count, hit_count);
    endfunction

    task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_total++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic add(input string nm, input logic lv, input logic [31:0] ld,
                       input logic fl, input logic st, input logic rv, input logic rh,
                       input logic [127:0] e);
        vec_t v;
        v.name = nm; v.ld_valid = lv; v.ld_data = ld; v.flush = fl;
        v.start = st; v.res_valid = rv; v.res_hit = rh; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic lv, input logic [31:0] ld, input logic fl,
                         input logic st, input logic rv, input logic rh);
        ld_valid = lv; ld_data = ld; flush = fl; start = st; res_valid = rv; res_hit = rh;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i].ld_valid, vecs[i].ld_data, vecs[i].flush,
                  vecs[i].start, vecs[i].res_valid, vecs[i].res_hit);
            @(negedge clk);
            check(vecs[i].name, act(), vecs[i].exp);
            tick();
        end
    endtask

    initial begin
        int n_phase1;
        int pv_cnt;
        int acc;
        logic got;

        // Phase 1: loads, flush, empty run, error in IDLE (pair_count 0).
        add("load0",          1, 32'h1111_1111, 0, 0, 0, 0, pk(1,1,1,0, 0,0,32'h1111_1111, 0,0,0,0, 0,0));
        add("load1",          1, 32'h2222_2222, 0, 0, 0, 0, pk(1,1,1,0, 1,0,32'h2222_2222, 0,0,0,0, 0,0));
        add("flush_over_load",1, 32'h3333_3333, 1, 0, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,0, 0,0));
        add("load_after_flush",1,32'h4444_4444, 0, 0, 0, 0, pk(1,1,1,0, 0,0,32'h4444_4444, 0,0,0,0, 0,0));
        add("flush2",         0, 0,             1, 0, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,0, 0,0));
        add("empty_start",    0, 0,             0, 1, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,0, 0,0));
        add("empty_done",     0, 0,             0, 0, 0, 0, pk(0,0,0,0, 0,0,0,            0,1,1,0, 0,0));
        add("empty_idle",     0, 0,             0, 0, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,0, 0,0));
        add("res_in_idle",    0, 0,             0, 0, 1, 1, pk(1,0,0,0, 0,0,0,            0,0,0,0, 0,0));
        add("err_set",        0, 0,             0, 0, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,1, 0,0));
        add("err_held",       0, 0,             0, 0, 0, 0, pk(1,0,0,0, 0,0,0,            0,0,0,1, 0,0));
        n_phase1 = vecs.size();
        // Two-pair run, cycle 0 = start cycle.
        add("run_c0_start",   0, 0, 0, 1, 0, 0, pk(1,0,0,0, 0,0,0, 0,0,0,1, 2,0));
        add("run_c1_rd0",     0, 0, 0, 0, 0, 0, pk(0,1,0,1, 0,0,0, 0,1,0,0, 2,0));
        add("run_c2_rd8",     0, 0, 0, 0, 0, 0, pk(0,1,0,1, 0,8,0, 1,1,0,0, 2,0));
        add("run_c3_last",    0, 0, 0, 0, 0, 0, pk(0,1,0,1, 0,8,0, 1,1,0,0, 2,0));
        add("run_c4_drain",   0, 0, 0, 0, 0, 0, pk(0,0,0,0, 0,0,0, 0,1,0,0, 2,0));
        add("run_c5_drain",   0, 0, 0, 0, 0, 0, pk(0,0,0,0, 0,0,0, 0,1,0,0, 2,0));
        add("run_c6_drain",   0, 0, 0, 0, 0, 0, pk(0,0,0,0, 0,0,0, 0,1,0,0, 2,0));
        add("run_c7_hit",     0, 0, 0, 0, 1, 1, pk(0,0,0,0, 0,0,0, 0,1,0,0, 2,0));
        add("run_c8_miss",    0, 0, 0, 0, 1, 0, pk(0,0,0,0, 0,0,0, 0,1,0,0, 2,1));
        add("run_c9_done",    0, 0, 0, 0, 0, 0, pk(0,0,0,0, 0,0,0, 0,1,1,0, 2,1));
        add("run_c10_idle",   0, 0, 0, 0, 0, 0, pk(1,0,0,0, 0,0,0, 0,0,0,0, 2,1));

        // Reset state.
        #3;
        check("reset_outputs", act(), '0);
        #10;
        rst_n = 1'b1;
        #1;
        check("post_reset", act(), pk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0));
        tick();

        apply(0, n_phase1);

        // Load two full records.
        for (int w = 0; w < 16; w++) begin
            drive(1, 32'hC000_0000 + 32'(w), 0, 0, 0, 0);
            @(negedge clk);
            check("load_word", {ram_cs, ram_we, ram_addr_in, ram_din},
                  {1'b1, 1'b1, 32'(w), 32'hC000_0000 + 32'(w)});
            tick();
        end

        apply(n_phase1, vecs.size());

        // Partial record: 12 words, 12th offered together with start.
        drive(0, 0, 1, 0, 0, 0);
        tick();
        for (int w = 0; w < 11; w++) begin
            drive(1, 32'hD000_0000 + 32'(w), 0, 0, 0, 0);
            tick();
        end
        drive(1, 32'hD000_000B, 0, 1, 0, 0);
        @(negedge clk);
        check("partial_load_with_start", {ram_we, ram_addr_in, ld_ready}, {1'b1, 32'd11, 1'b1});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        pv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pipe_valid) pv_cnt++;
            if (k == 0) check("partial_pair_count", 128'(pair_count), 128'd1);
            tick();
        end
        check("partial_one_issue", 128'(pv_cnt), 128'd1);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            tick();
        end
        check("partial_done_seen", 128'(got), 128'd1);
        check("partial_hits", 128'(hit_count), 128'd0);

        // Full store: offer 33 words back to back.
        drive(0, 0, 1, 0, 0, 0);
        tick();
        acc = 0;
        for (int i = 0; i < 33; i++) begin
            drive(1, 32'hE000_0000 + 32'(i), 0, 0, 0, 0);
            @(negedge clk);
            if (ld_ready) acc++;
            if (i == 31) check("full_32nd_accept", {ld_ready, ram_we, ram_addr_in}, {1'b1, 1'b1, 32'd31});
            if (i == 32) check("full_33rd_held", {ld_ready, ram_we, ram_cs}, 3'b000);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("full_accepts", 128'(acc), 128'd32);
        check("full_pair_count", 128'(pair_count), 128'd4);
        tick();

        // Four-pair run left in DRAIN, then reset with a load offered.
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) tick();
        @(negedge clk);
        check("drain_state", {busy, ram_cs, ram_oe, pipe_valid, done}, 5'b10000);
        tick();
        drive(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("reset_in_drain", act(), '0);
        @(negedge clk);
        check("reset_held", act(), '0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check("after_drain_reset", act(), pk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0));
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
